gigex_tx_mux: RTL

//  Parametrised multi-channel transmit multiplexer for the GigEx byte interface, eth_clk domain.

---
 rtl/gigex_pkg.sv | 17 +
 rtl/gigex_rr_arbiter.sv | 52 +++++
 rtl/gigex_tx_mux.sv | 119 +++++++++++
 3 files changed

// File: rtl/gigex_pkg.sv
// Shared constants, output beat payload and byte-order helper for the GigEx Tx path.
package gigex_pkg;
   localparam int unsigned GIGEX_TC_W    = 3;
   localparam int unsigned GIGEX_NCH_MAX = 8;
   localparam int unsigned ARB_FIXED     = 0;
   localparam int unsigned ARB_RR        = 1;

   typedef struct packed {
      logic [GIGEX_TC_W-1:0] tc;
      logic [7:0]            data;
   } tx_beat_t;

   // Byte lane of a word sent at serial position idx; the MSB lane goes first.
   function automatic int unsigned byte_lane(input int unsigned idx, input int unsigned word_bytes);
      return word_bytes - 1 - idx;
   endfunction
endpackage

// File: rtl/gigex_rr_arbiter.sv
// N-way single-grant arbiter: fixed priority (highest index wins) or round-robin after the last grant.
module gigex_rr_arbiter
   import gigex_pkg::*;
#(
   parameter int unsigned N    = 2,
   parameter int unsigned MODE = ARB_FIXED,
   parameter int unsigned IW   = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  grant_c,
   output logic [IW-1:0] idx_c,
   output logic          any_c
);
   logic [IW-1:0] ptr;
   logic [IW-1:0] cand;

   always_comb begin
      idx_c   = '0;
      any_c   = 1'b0;
      cand    = '0;
      grant_c = '0;
      if (MODE == ARB_RR) begin
         // Walk from the farthest candidate back so the nearest one after ptr is kept.
         for (int unsigned k = N; k >= 1; k--) begin
            cand = IW'((32'(ptr) + k) % N);
            if (req[cand]) begin
               idx_c = cand;
               any_c = 1'b1;
            end
         end
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            if (req[i]) begin
               idx_c = IW'(i);
               any_c = 1'b1;
            end
         end
      end
      grant_c[idx_c] = any_c;
   end

   // Pointer starts at the last channel so channel 0 is served first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= IW'(N - 1);
      end else if (any_c) begin
         ptr <= idx_c;
      end
   end
endmodule

// File: rtl/gigex_tx_mux.sv
// Multi-channel GigEx transmit mux: serialises per-channel words MSB first onto the shared
// D/TC/nTx byte bus, throttled per channel by the delayed nTF full flags.
module gigex_tx_mux
   import gigex_pkg::*;
#(
   parameter int unsigned N_CH       = 2,
   parameter int unsigned WORD_BYTES = 4,
   parameter int unsigned ARB_MODE   = ARB_FIXED,
   parameter int unsigned NTF_DLY    = 2
) (
   input  logic                         eth_clk,
   input  logic                         rst_n,
   input  logic [N_CH*WORD_BYTES*8-1:0] s_data,
   input  logic [N_CH-1:0]              s_valid,
   output logic [N_CH-1:0]              s_ready,
   input  logic [GIGEX_NCH_MAX-1:0]     nTF,
   output logic [7:0]                   D,
   output logic [GIGEX_TC_W-1:0]        TC,
   output logic                         nTx,
   output logic [31:0]                  tx_bytes,
   output logic                         busy
);
   localparam int unsigned WORD_W = WORD_BYTES * 8;
   localparam int unsigned IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

   logic [N_CH-1:0] ntf_d [NTF_DLY+1];
   logic [N_CH-1:0] tx_ok;
   logic [N_CH-1:0] loaded;
   logic [N_CH-1:0] eligible;
   logic [N_CH-1:0] grant;
   logic [N_CH-1:0] last;
   logic [N_CH-1:0] accept;
   logic [7:0]      cur_byte [N_CH];
   logic [CH_W-1:0] gidx;
   logic            gany;
   tx_beat_t        beat;
   logic            unused_ntf;

   // nTF bits above N_CH have no channel behind them.
   assign unused_ntf = &{1'b0, nTF};

   // Full flags reach the arbiter only through the pipe; reset value 0 reads as full.
   always_ff @(posedge eth_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned s = 0; s <= NTF_DLY; s++) ntf_d[s] <= '0;
      end else begin
         ntf_d[0] <= nTF[N_CH-1:0];
         for (int unsigned s = 1; s <= NTF_DLY; s++) ntf_d[s] <= ntf_d[s-1];
      end
   end

   assign tx_ok    = ntf_d[NTF_DLY-1] | ntf_d[NTF_DLY];
   assign eligible = loaded & tx_ok;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [WORD_BYTES-1:0][7:0] hold_q;
      logic [IDX_W-1:0]           idx_q;
      logic                       loaded_q;
      logic [IDX_W-1:0]           lane;

      assign loaded[i]   = loaded_q;
      assign last[i]     = (idx_q == LAST_IDX);
      // Ready on the last byte's grant lets the next word follow with no gap cycle.
      assign s_ready[i]  = rst_n & (~loaded_q | (grant[i] & last[i]));
      assign accept[i]   = s_valid[i] & s_ready[i];
      assign lane        = IDX_W'(byte_lane(32'(idx_q), WORD_BYTES));
      assign cur_byte[i] = hold_q[lane];

      always_ff @(posedge eth_clk or negedge rst_n) begin
         if (!rst_n) begin
            hold_q   <= '0;
            idx_q    <= '0;
            loaded_q <= 1'b0;
         end else if (accept[i]) begin
            hold_q   <= s_data[i*WORD_W +: WORD_W];
            idx_q    <= '0;
            loaded_q <= 1'b1;
         end else if (grant[i]) begin
            idx_q <= idx_q + IDX_W'(1);
            if (last[i]) loaded_q <= 1'b0;
         end
      end
   end

   gigex_rr_arbiter #(
      .N    (N_CH),
      .MODE (ARB_MODE),
      .IW   (CH_W)
   ) u_arb (
      .clk     (eth_clk),
      .rst_n   (rst_n),
      .req     (eligible),
      .grant_c (grant),
      .idx_c   (gidx),
      .any_c   (gany)
   );

   // Output beat: strobe the granted byte, otherwise hold D/TC with nTx high.
   always_ff @(posedge eth_clk or negedge rst_n) begin
      if (!rst_n) begin
         nTx      <= 1'b1;
         beat     <= '0;
         tx_bytes <= '0;
      end else if (gany) begin
         nTx       <= 1'b0;
         beat.tc   <= GIGEX_TC_W'(gidx);
         beat.data <= cur_byte[gidx];
         tx_bytes  <= tx_bytes + 32'd1;
      end else begin
         nTx <= 1'b1;
      end
   end

   assign D    = beat.data;
   assign TC   = beat.tc;
   assign busy = |loaded;
endmodule
